// File: rtl/fifo_buffer.sv
// Synchronous show-ahead FIFO with its own storage, occupancy flags and sticky error flags.
// Push is refused while full and pop while empty; rst and clr both empty the queue.
module fifo_buffer #(
    parameter int NUM_DATA  = 8,
    parameter int DATA_BW   = 8,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 2,
    localparam int ADDR_BW  = $clog2(NUM_DATA)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               wr_din,
    input  logic [DATA_BW-1:0] din,
    input  logic               rd_dout,
    output logic [DATA_BW-1:0] dout,
    output logic [ADDR_BW:0]   num_item,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic               overflow,
    output logic               underflow
);

    localparam logic [ADDR_BW:0]   FULL_CNT   = NUM_DATA[ADDR_BW:0];
    localparam logic [ADDR_BW:0]   AFULL_CNT  = AFULL_TH[ADDR_BW:0];
    localparam logic [ADDR_BW:0]   AEMPTY_CNT = AEMPTY_TH[ADDR_BW:0];
    localparam logic [ADDR_BW:0]   CNT_ONE    = (ADDR_BW + 1)'(1);
    localparam logic [ADDR_BW-1:0] PTR_ONE    = ADDR_BW'(1);

    logic [DATA_BW-1:0] mem_q [NUM_DATA];
    logic [ADDR_BW-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_BW-1:0] rdPtr_q, rdPtr_d;
    logic [ADDR_BW:0]   numItem_q, numItem_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic               push, pop;

    // All flags decode the registered count only, so no request reaches an output combinationally.
    assign full         = (numItem_q == FULL_CNT);
    assign empty        = (numItem_q == '0);
    assign almost_full  = (numItem_q >= AFULL_CNT);
    assign almost_empty = (numItem_q <= AEMPTY_CNT);
    assign num_item     = numItem_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign dout         = empty ? '0 : mem_q[rdPtr_q];

    always_comb begin
        push        = wr_din & ~full;
        pop         = rd_dout & ~empty;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        numItem_d   = numItem_q;
        overflow_d  = overflow_q | (wr_din & full);
        underflow_d = underflow_q | (rd_dout & empty);
        if (push) begin
            wrPtr_d = wrPtr_q + PTR_ONE;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   numItem_d = numItem_q + CNT_ONE;
            2'b01:   numItem_d = numItem_q - CNT_ONE;
            default: numItem_d = numItem_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            numItem_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            numItem_q   <= numItem_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never cleared; stale entries stay hidden because dout is forced to zero when empty.
    always_ff @(posedge clk) begin
        if (push && !rst && !clr) begin
            mem_q[wrPtr_q] <= din;
        end
    end

endmodule
